// File: rtl/irrigation_scheduler_if.sv
// irrigation_scheduler_if: requester/tank inputs and valve/status outputs of the irrigation scheduler.
interface irrigation_scheduler_if;
    logic       tick;
    logic       req_asp;
    logic       req_got;
    logic       req_adb;
    logic [2:0] level;
    logic       valve_open;
    logic [1:0] grant;
    logic       fert_on;
    logic       erro;
    logic [2:0] state;
    modport master (output tick, req_asp, req_got, req_adb, level,
                    input  valve_open, grant, fert_on, erro, state);
    modport slave  (input  tick, req_asp, req_got, req_adb, level,
                    output valve_open, grant, fert_on, erro, state);
endinterface

// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler: round-robin valve time-slot scheduler for sprinkler, drip and fertilizer line cleaning.
module irrigation_scheduler #(
    parameter int ASP_SLOT    = 20,
    parameter int GOT_SLOT    = 40,
    parameter int CLEAN_SLOT  = 10,
    parameter int GUARD_TICKS = 2,
    parameter int TIMER_W     = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    irrigation_scheduler_if.slave if_bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ASP   = 3'd1,
        S_GOT   = 3'd2,
        S_CLEAN = 3'd3,
        S_GUARD = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    localparam logic [TIMER_W-1:0] ASP_END   = TIMER_W'(ASP_SLOT - 1);
    localparam logic [TIMER_W-1:0] GOT_END   = TIMER_W'(GOT_SLOT - 1);
    localparam logic [TIMER_W-1:0] CLEAN_END = TIMER_W'(CLEAN_SLOT - 1);
    localparam logic [TIMER_W-1:0] GUARD_END = TIMER_W'(GUARD_TICKS - 1);

    state_t             r_state;
    state_t             w_nxt;
    logic [TIMER_W-1:0] r_timer;
    logic               r_last_got;
    logic               r_adb;
    logic               r_clean;
    logic               w_last_got;
    logic               w_adb;
    logic               w_clean;
    logic               w_asp_ok;
    logic               w_timed;
    logic               w_valve;

    assign w_asp_ok = if_bus.req_asp & if_bus.level[1];
    assign w_timed  = r_state inside {S_ASP, S_GOT, S_CLEAN, S_GUARD};
    assign w_valve  = w_nxt inside {S_ASP, S_GOT, S_CLEAN};
    assign if_bus.state = r_state;

    always_comb begin
        w_nxt      = r_state;
        w_last_got = r_last_got;
        w_clean    = r_clean;
        w_adb      = r_adb | if_bus.req_adb;
        if (if_bus.level == 3'b000)
            w_nxt = S_FAULT;
        else
            case (r_state)
                S_IDLE: w_nxt = r_clean ? S_CLEAN :
                                (w_asp_ok & if_bus.req_got) ? (r_last_got ? S_ASP : S_GOT) :
                                w_asp_ok ? S_ASP : if_bus.req_got ? S_GOT : S_IDLE;
                S_ASP: begin
                    // A normal end consumes the fertilizer request, including one arriving this clock
                    if (if_bus.tick && r_timer == ASP_END) begin
                        w_nxt      = S_GUARD;
                        w_last_got = 1'b0;
                        w_adb      = 1'b0;
                        w_clean    = r_clean | r_adb;
                    end else if (!if_bus.req_asp) begin
                        w_nxt      = S_GUARD;
                        w_last_got = 1'b0;
                    end
                end
                S_GOT: if ((if_bus.tick && r_timer == GOT_END) || !if_bus.req_got) begin
                    w_nxt      = S_GUARD;
                    w_last_got = 1'b1;
                end
                S_CLEAN: if (if_bus.tick && r_timer == CLEAN_END) begin
                    w_nxt   = S_GUARD;
                    w_clean = 1'b0;
                end
                S_GUARD: w_nxt = (if_bus.tick && r_timer == GUARD_END) ? S_IDLE : S_GUARD;
                S_FAULT: w_nxt = if_bus.level[1] ? S_GUARD : S_FAULT;
                default: w_nxt = S_IDLE;
            endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state           <= S_IDLE;
            r_timer           <= '0;
            r_last_got        <= 1'b1;
            r_adb             <= 1'b0;
            r_clean           <= 1'b0;
            if_bus.valve_open <= 1'b0;
            if_bus.grant      <= 2'b00;
            if_bus.fert_on    <= 1'b0;
            if_bus.erro       <= 1'b0;
        end else begin
            r_state           <= w_nxt;
            r_timer           <= (w_nxt != r_state) ? '0 : (if_bus.tick && w_timed) ? r_timer + 1'b1 : r_timer;
            r_last_got        <= w_last_got;
            r_adb             <= w_adb;
            r_clean           <= w_clean;
            if_bus.valve_open <= w_valve;
            // Slot state codes coincide with their grant encoding
            if_bus.grant      <= w_valve ? w_nxt[1:0] : 2'b00;
            if_bus.fert_on    <= (w_nxt == S_ASP) && w_adb;
            if_bus.erro       <= (w_nxt == S_FAULT);
        end
    end
endmodule

// File: tb/tb_irrigation_scheduler.sv
// tb_irrigation_scheduler: directed scenarios plus randomized traffic against a behavioural slot model.
module tb_irrigation_scheduler;
    localparam int ASP_SLOT    = 4;
    localparam int GOT_SLOT    = 6;
    localparam int CLEAN_SLOT  = 3;
    localparam int GUARD_TICKS = 2;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic tb_tick = 1'b0;
    int   tick_cnt = 0;
    int   checks = 0;
    int   passed = 0;

    irrigation_scheduler_if ifc ();
    assign ifc.tick = tb_tick;

    irrigation_scheduler #(
        .ASP_SLOT(ASP_SLOT), .GOT_SLOT(GOT_SLOT), .CLEAN_SLOT(CLEAN_SLOT),
        .GUARD_TICKS(GUARD_TICKS), .TIMER_W(8)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .if_bus(ifc)
    );

    always #5 clk = ~clk;

    // One-clock tick every 4 clocks, changed away from the sampling edge
    always @(posedge clk) begin
        #2;
        tick_cnt = (tick_cnt + 1) % 4;
        tb_tick = (tick_cnt == 0);
    end

    logic [7:0] obs;
    assign obs = {ifc.valve_open, ifc.grant, ifc.fert_on, ifc.erro, ifc.state};

    // Reference model: current activity plus remaining ticks in it
    int         m_st = 0, m_nst = 0, m_rem = 0;
    bit         m_last_got = 1, m_adb = 0, m_clean = 0, m_fin = 0, m_ok = 0;
    logic [7:0] m_out = 8'h00;

    function automatic int slot_len(int s);
        return s == 1 ? ASP_SLOT : s == 2 ? GOT_SLOT : s == 3 ? CLEAN_SLOT : GUARD_TICKS;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_rem = 0; m_last_got = 1; m_adb = 0; m_clean = 0;
        end else begin
            m_nst = m_st;
            m_fin = 0;
            m_ok  = ifc.req_asp && ifc.level[1];
            if (ifc.level == 3'b000) m_nst = 5;
            else if (m_st == 0)
                m_nst = m_clean ? 3 : (m_ok && ifc.req_got) ? (m_last_got ? 1 : 2) :
                        m_ok ? 1 : ifc.req_got ? 2 : 0;
            else if (m_st == 5) m_nst = ifc.level[1] ? 4 : 5;
            else begin
                m_fin = ifc.tick && m_rem == 1;
                if (m_fin || (m_st == 1 && !ifc.req_asp) || (m_st == 2 && !ifc.req_got))
                    m_nst = (m_st == 4) ? 0 : 4;
                if (m_nst == m_st && ifc.tick) m_rem--;
                if (m_nst == 4 && m_st == 1) m_last_got = 0;
                if (m_nst == 4 && m_st == 2) m_last_got = 1;
                if (m_nst == 4 && m_st == 3) m_clean = 0;
            end
            if (m_st == 1 && m_fin) begin
                m_clean = m_clean || m_adb;
                m_adb = 0;
            end else m_adb = m_adb || ifc.req_adb;
            if (m_nst != m_st) m_rem = slot_len(m_nst);
            m_st = m_nst;
        end
        m_out = {m_st inside {1, 2, 3},
                 m_st == 1 ? 2'b01 : m_st == 2 ? 2'b10 : m_st == 3 ? 2'b11 : 2'b00,
                 m_st == 1 && m_adb, m_st == 5, 3'(m_st)};
    end

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (obs !== 8'h00) $display("FAIL reset_outputs: got %b want %b", obs, 8'h00); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_asp_slot;
        int n;
        ifc.req_asp = 1'b1;
        @(negedge clk);
        checks++; if ({ifc.valve_open, ifc.grant} !== 3'b101) $display("FAIL asp_grant: got %b want %b", {ifc.valve_open, ifc.grant}, 3'b101); else passed++;
        n = 0;
        for (int k = 0; k < 200 && ifc.valve_open; k++) begin
            if (ifc.tick) n++;
            @(negedge clk);
            checks++; if (obs !== m_out) $display("FAIL model_asp: got %b want %b", obs, m_out); else passed++;
        end
        checks++; if (n !== ASP_SLOT || ifc.state !== 3'd4) $display("FAIL asp_ticks: got %0d/%0d want %0d/4", n, ifc.state, ASP_SLOT); else passed++;
        n = 0;
        for (int k = 0; k < 200 && ifc.state == 3'd4; k++) begin
            if (ifc.tick) n++;
            checks++; if (ifc.valve_open !== 1'b0) $display("FAIL guard_valve: got %b want 0", ifc.valve_open); else passed++;
            @(negedge clk);
        end
        checks++; if (n !== GUARD_TICKS || ifc.state !== 3'd0) $display("FAIL guard_ticks: got %0d/%0d want %0d/0", n, ifc.state, GUARD_TICKS); else passed++;
        @(negedge clk);
        checks++; if (ifc.grant !== 2'b01) $display("FAIL asp_again: got %b want 01", ifc.grant); else passed++;
    endtask

    task automatic test_round_robin;
        int   cnt;
        bit   prev, saw_guard;
        logic [1:0] exp;
        ifc.req_got = 1'b1;
        cnt = 0; prev = 1'b1; saw_guard = 1'b0;
        for (int k = 0; k < 600 && cnt < 4; k++) begin
            @(negedge clk);
            checks++; if (obs !== m_out) $display("FAIL model_rr: got %b want %b", obs, m_out); else passed++;
            if (ifc.state == 3'd4) saw_guard = 1'b1;
            if (ifc.valve_open && !prev) begin
                exp = (cnt % 2 == 0) ? 2'b10 : 2'b01;
                checks++; if ({saw_guard, ifc.grant} !== {1'b1, exp}) $display("FAIL rr_slot%0d: got guard=%b grant=%b want guard=1 grant=%b", cnt, saw_guard, ifc.grant, exp); else passed++;
                saw_guard = 1'b0;
                cnt++;
            end
            prev = ifc.valve_open;
        end
        checks++; if (cnt !== 4) $display("FAIL rr_count: got %0d want 4", cnt); else passed++;
        ifc.req_asp = 1'b0; ifc.req_got = 1'b0;
        for (int k = 0; k < 200 && ifc.state != 3'd0; k++) @(negedge clk);
        checks++; if (ifc.state !== 3'd0) $display("FAIL rr_idle: got %0d want 0", ifc.state); else passed++;
    endtask

    task automatic test_fert_clean;
        int n;
        bit seen_asp, seen_fert;
        ifc.req_adb = 1'b1;
        @(negedge clk);
        ifc.req_adb = 1'b0; ifc.req_asp = 1'b1;
        @(negedge clk);
        checks++; if ({ifc.grant, ifc.fert_on} !== 3'b011) $display("FAIL fert_grant: got %b want %b", {ifc.grant, ifc.fert_on}, 3'b011); else passed++;
        for (int k = 0; k < 200 && ifc.valve_open; k++) begin
            @(negedge clk);
            checks++; if (obs !== m_out) $display("FAIL model_fert: got %b want %b", obs, m_out); else passed++;
        end
        ifc.req_asp = 1'b0;
        for (int k = 0; k < 200 && !ifc.valve_open; k++) @(negedge clk);
        checks++; if ({ifc.grant, ifc.fert_on} !== 3'b110) $display("FAIL clean_grant: got %b want %b", {ifc.grant, ifc.fert_on}, 3'b110); else passed++;
        n = 0;
        for (int k = 0; k < 200 && ifc.grant == 2'b11; k++) begin
            if (ifc.tick) n++;
            @(negedge clk);
            checks++; if (obs !== m_out) $display("FAIL model_clean: got %b want %b", obs, m_out); else passed++;
        end
        checks++; if (n !== CLEAN_SLOT) $display("FAIL clean_ticks: got %0d want %0d", n, CLEAN_SLOT); else passed++;
        ifc.req_asp = 1'b1; seen_asp = 1'b0; seen_fert = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (ifc.grant == 2'b01) seen_asp = 1'b1;
            if (ifc.fert_on) seen_fert = 1'b1;
        end
        checks++; if ({seen_asp, seen_fert} !== 2'b10) $display("FAIL fert_after_clean: got asp=%b fert=%b want asp=1 fert=0", seen_asp, seen_fert); else passed++;
        ifc.req_asp = 1'b0;
        for (int k = 0; k < 200 && ifc.state != 3'd0; k++) @(negedge clk);
    endtask

    task automatic test_fault;
        ifc.req_got = 1'b1;
        for (int k = 0; k < 100 && ifc.grant != 2'b10; k++) @(negedge clk);
        checks++; if (ifc.grant !== 2'b10) $display("FAIL fault_got_grant: got %b want 10", ifc.grant); else passed++;
        repeat (5) @(negedge clk);
        ifc.level = 3'b000; ifc.req_got = 1'b0;
        @(negedge clk);
        checks++; if ({ifc.erro, ifc.valve_open, ifc.state} !== 5'b10101) $display("FAIL fault_entry: got %b want %b", {ifc.erro, ifc.valve_open, ifc.state}, 5'b10101); else passed++;
        repeat (3) begin
            @(negedge clk);
            checks++; if (obs !== m_out) $display("FAIL model_fault: got %b want %b", obs, m_out); else passed++;
        end
        ifc.level = 3'b011;
        @(negedge clk);
        checks++; if ({ifc.erro, ifc.state} !== 4'b0100) $display("FAIL fault_exit: got %b want %b", {ifc.erro, ifc.state}, 4'b0100); else passed++;
        for (int k = 0; k < 100 && ifc.state != 3'd0; k++) @(negedge clk);
        checks++; if ({ifc.erro, ifc.state} !== 4'b0000) $display("FAIL fault_idle: got %b want 0000", {ifc.erro, ifc.state}); else passed++;
    endtask

    task automatic test_low_level;
        bit bad;
        ifc.level = 3'b001; ifc.req_asp = 1'b1; bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ifc.grant != 2'b00 || ifc.state != 3'd0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) $display("FAIL low_level_hold: got granted=%b want 0", bad); else passed++;
        ifc.level = 3'b011;
        @(negedge clk);
        checks++; if ({ifc.valve_open, ifc.grant} !== 3'b101) $display("FAIL low_level_release: got %b want 101", {ifc.valve_open, ifc.grant}); else passed++;
        ifc.req_asp = 1'b0; ifc.level = 3'b111;
        for (int k = 0; k < 100 && ifc.state != 3'd0; k++) @(negedge clk);
    endtask

    task automatic test_reset_mid_clean;
        bit seen_clean;
        ifc.req_adb = 1'b1;
        @(negedge clk);
        ifc.req_adb = 1'b0; ifc.req_asp = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 200 && ifc.valve_open; k++) @(negedge clk);
        ifc.req_asp = 1'b0;
        for (int k = 0; k < 200 && ifc.grant != 2'b11; k++) @(negedge clk);
        checks++; if (ifc.grant !== 2'b11) $display("FAIL rst_clean_reach: got %b want 11", ifc.grant); else passed++;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (obs !== 8'h00) $display("FAIL rst_async: got %b want %b", obs, 8'h00); else passed++;
        @(negedge clk);
        rst_n = 1'b1; seen_clean = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (ifc.grant == 2'b11) seen_clean = 1'b1;
        end
        checks++; if (seen_clean !== 1'b0) $display("FAIL rst_no_clean: got %b want 0", seen_clean); else passed++;
    endtask

    task automatic test_random;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            checks++; if (obs !== m_out) $display("FAIL model_random@%0d: got %b want %b", c, obs, m_out); else passed++;
            if ($urandom_range(0, 7) == 0) ifc.req_asp = ~ifc.req_asp;
            if ($urandom_range(0, 7) == 0) ifc.req_got = ~ifc.req_got;
            ifc.req_adb = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 59) == 0)
                case ($urandom_range(0, 3))
                    0: ifc.level = 3'b000;
                    1: ifc.level = 3'b001;
                    2: ifc.level = 3'b011;
                    default: ifc.level = 3'b111;
                endcase
        end
    endtask

    initial begin
        ifc.req_asp = 1'b0;
        ifc.req_got = 1'b0;
        ifc.req_adb = 1'b0;
        ifc.level   = 3'b111;
        test_reset();
        test_asp_slot();
        test_round_robin();
        test_fert_clean();
        test_fault();
        test_low_level();
        test_reset_mid_clean();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
